// File: rtl/nn_pkg.sv
// Shared types and default widths for the neuron datapath and the layer controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package nn_pkg;

   localparam int NN_DATA_W   = 16;
   localparam int NN_FRAC_W   = 8;
   localparam int NN_ACC_W    = 32;
   localparam int NN_N_INPUTS = 64;

   // Code 3 is reserved and behaves as identity.
   typedef enum logic [1:0] {
      ACT_ID   = 2'd0,
      ACT_RELU = 2'd1,
      ACT_CLIP = 2'd2,
      ACT_RSVD = 2'd3
   } act_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_ACT   = 2'd2,
      ST_DONE  = 2'd3
   } node_state_t;

endpackage

// File: rtl/node_act.sv
// Activation stage: rescale accumulator to output Q format, clamp to DATA_W, apply activation.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module node_act
   import nn_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int FRAC_W = NN_FRAC_W,
   parameter int ACC_W  = NN_ACC_W
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  act_mode_t                act_mode,
   output logic signed [DATA_W-1:0] result,
   output logic                     clamped
);

   // Output-range bounds expressed at accumulator width so the whole rescaled value is compared.
   localparam logic signed [ACC_W-1:0]  R_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0]  R_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] ONE   = DATA_W'(1) << FRAC_W;

   logic signed [ACC_W-1:0]  r_full;
   logic signed [DATA_W-1:0] sat_r;

   // Drop the extra fraction bits, saturate into DATA_W, then shape by activation mode.
   always_comb begin
      r_full  = acc >>> FRAC_W;
      sat_r   = r_full[DATA_W-1:0];
      clamped = 1'b0;
      if (r_full > R_MAX) begin
         sat_r   = R_MAX[DATA_W-1:0];
         clamped = 1'b1;
      end else if (r_full < R_MIN) begin
         sat_r   = R_MIN[DATA_W-1:0];
         clamped = 1'b1;
      end
      result = sat_r;
      case (act_mode)
         ACT_RELU: begin
            if (sat_r[DATA_W-1]) result = '0;
         end
         ACT_CLIP: begin
            if (sat_r[DATA_W-1])  result = '0;
            else if (sat_r > ONE) result = ONE;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mac_node.sv
// Fixed-point neuron: bias + saturating sum of N_INPUTS products, then activation.
// Latency: first beat the cycle after start; out_valid N_INPUTS+1 cycles after the first beat.
// Backpressure: in_valid low stalls accumulation; result held in DONE until out_ready.
module mac_node
   import nn_pkg::*;
#(
   parameter int DATA_W   = NN_DATA_W,
   parameter int FRAC_W   = NN_FRAC_W,
   parameter int ACC_W    = NN_ACC_W,
   parameter int N_INPUTS = NN_N_INPUTS
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     start,
   input  logic                     clear,
   input  logic signed [DATA_W-1:0] bias,
   input  logic [1:0]               act_mode,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic signed [DATA_W-1:0] in_coef,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     busy,
   output logic                     sat_flag
);

   localparam int                      CNT_W   = $clog2(N_INPUTS + 1);
   localparam logic [CNT_W-1:0]        LAST    = CNT_W'(N_INPUTS - 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   node_state_t               state;
   act_mode_t                 mode_q;
   logic signed [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]          count;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W:0]     sum;
   logic signed [ACC_W-1:0]   acc_next;
   logic                      ovf;
   logic signed [DATA_W-1:0]  act_result;
   logic                      act_clamp;

   // Exact product, one-bit-wider sum, and clamp to the accumulator range on signed overflow.
   always_comb begin
      prod     = (2*DATA_W)'(in_data) * (2*DATA_W)'(in_coef);
      sum      = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
      ovf      = sum[ACC_W] != sum[ACC_W-1];
      acc_next = sum[ACC_W-1:0];
      if (ovf) acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
   end

   node_act #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_act (
      .acc      (acc),
      .act_mode (mode_q),
      .result   (act_result),
      .clamped  (act_clamp)
   );

   // Operation sequencer; clear aborts from any state but keeps out_data and sat_flag.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= ST_IDLE;
         mode_q    <= ACT_ID;
         acc       <= '0;
         count     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         sat_flag  <= 1'b0;
      end else if (clear) begin
         state     <= ST_IDLE;
         acc       <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_ACCUM;
                  acc      <= ACC_W'(bias) <<< FRAC_W;
                  count    <= '0;
                  sat_flag <= 1'b0;
                  mode_q   <= act_mode_t'(act_mode);
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_ACCUM: begin
               if (in_valid) begin
                  acc   <= acc_next;
                  count <= count + CNT_W'(1);
                  if (ovf) sat_flag <= 1'b1;
                  if (count == LAST) begin
                     state    <= ST_ACT;
                     in_ready <= 1'b0;
                  end
               end
            end
            ST_ACT: begin
               out_data  <= act_result;
               out_valid <= 1'b1;
               if (act_clamp) sat_flag <= 1'b1;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
